// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle (data, valid, last, ready) used for both sides of axis_pkt_fifo.
interface axis_pkt_fifo_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is emitted only after its TLAST beat is stored.
// Define AXIS_PKT_FIFO_PKT_COUNT_EN to build the emitted-packet counter driven on pkt_count.
module axis_pkt_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic            ACLK,
   input  logic            ARESETn,
   axis_pkt_fifo_if.slave  s_axis,
   axis_pkt_fifo_if.master m_axis,
   output logic [AW:0]     words_stored,
   output logic [AW:0]     pkts_stored,
   output logic            oversize_err,
   input  logic            err_clr,
   output logic [15:0]     pkt_count
);

   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] MSB_ONLY = {1'b1, {AW{1'b0}}};

   logic [DATA_W:0]   mem [DEPTH];
   logic [DATA_W:0]   ram_rd_q;

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       commit_ptr_q, commit_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fetch_ptr_q, fetch_ptr_d;
   logic [AW:0]       pkts_q, pkts_d;
   logic              s_ready_q, s_ready_d;
   logic              stage_valid_q, stage_valid_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              err_q, err_d;

   logic              wr_en, wr_last, oversize_hit, commit;
   logic              emit, emit_last, out_ready, rd_en;

   // rd_ptr advances only on emission, so wr_ptr - rd_ptr counts words in RAM plus the output pipeline.
   // fetch_ptr is the RAM read address and never passes commit_ptr.
   always_comb begin
      wr_en        = s_axis.tvalid && s_ready_q;
      oversize_hit = wr_en && !s_axis.tlast && ((wr_ptr_q + PTR_ONE - commit_ptr_q) == MSB_ONLY);
      wr_last      = s_axis.tlast || oversize_hit;
      commit       = wr_en && wr_last;
      emit         = out_valid_q && m_axis.tready;
      emit_last    = emit && out_last_q;
      out_ready    = !out_valid_q || m_axis.tready;
      rd_en        = (fetch_ptr_q != commit_ptr_q) && (!stage_valid_q || out_ready);

      wr_ptr_d     = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      commit_ptr_d = commit ? wr_ptr_d : commit_ptr_q;
      rd_ptr_d     = emit ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      fetch_ptr_d  = rd_en ? fetch_ptr_q + PTR_ONE : fetch_ptr_q;
      s_ready_d    = (wr_ptr_d ^ rd_ptr_d) != MSB_ONLY;

      stage_valid_d = rd_en || (stage_valid_q && !out_ready);
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      out_data_d    = out_data_q;
      if (out_ready) begin
         out_valid_d = stage_valid_q;
         if (stage_valid_q) begin
            out_data_d = ram_rd_q[DATA_W-1:0];
            out_last_d = ram_rd_q[DATA_W];
         end
      end

      pkts_d = pkts_q;
      case ({commit, emit_last})
         2'b10:   pkts_d = pkts_q + PTR_ONE;
         2'b01:   pkts_d = pkts_q - PTR_ONE;
         default: pkts_d = pkts_q;
      endcase

      err_d = err_q;
      if (oversize_hit) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rd_ptr_q      <= '0;
         fetch_ptr_q   <= '0;
         pkts_q        <= '0;
         s_ready_q     <= 1'b0;
         stage_valid_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_data_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fetch_ptr_q   <= fetch_ptr_d;
         pkts_q        <= pkts_d;
         s_ready_q     <= s_ready_d;
         stage_valid_q <= stage_valid_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         out_data_q    <= out_data_d;
         err_q         <= err_d;
      end
   end

   // Reads stay below commit_ptr and writes at or above it, so the two ports never share an address.
   always_ff @(posedge ACLK) begin
      if (wr_en) begin
         mem[wr_ptr_q[AW-1:0]] <= {wr_last, s_axis.tdata};
      end
      if (rd_en) begin
         ram_rd_q <= mem[fetch_ptr_q[AW-1:0]];
      end
   end

`ifdef AXIS_PKT_FIFO_PKT_COUNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = emit_last ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_count = pkt_cnt_q;
`else
   assign pkt_count = '0;
`endif

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tlast  = out_last_q;
   assign m_axis.tdata  = out_data_q;
   assign words_stored  = wr_ptr_q - rd_ptr_q;
   assign pkts_stored   = pkts_q;
   assign oversize_err  = err_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: a DEPTH=512 instance for streaming cases and a DEPTH=8 instance
// for full/oversize cases; sel routes the shared stimulus and observation to one of them.
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        sel;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tlast, m_tready, err_clr;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          first_emit = 0;
   int          last_emit = 0;
   logic [32:0] out_q[$];

   always #5 ACLK = ~ACLK;

   axis_pkt_fifo_if #(.DATA_W(32)) big_s ();
   axis_pkt_fifo_if #(.DATA_W(32)) big_m ();
   axis_pkt_fifo_if #(.DATA_W(32)) small_s ();
   axis_pkt_fifo_if #(.DATA_W(32)) small_m ();

   logic [9:0]  big_words, big_pkts;
   logic [3:0]  small_words, small_pkts;
   logic        big_err, small_err, big_clr, small_clr;
   logic [15:0] big_cnt, small_cnt;

   assign big_s.tdata    = s_tdata;
   assign big_s.tvalid   = s_tvalid && !sel;
   assign big_s.tlast    = s_tlast;
   assign big_m.tready   = m_tready && !sel;
   assign big_clr        = err_clr && !sel;
   assign small_s.tdata  = s_tdata;
   assign small_s.tvalid = s_tvalid && sel;
   assign small_s.tlast  = s_tlast;
   assign small_m.tready = m_tready && sel;
   assign small_clr      = err_clr && sel;

   axis_pkt_fifo #(.DATA_W(32), .DEPTH(512)) u_big (
      .ACLK(ACLK), .ARESETn(ARESETn), .s_axis(big_s), .m_axis(big_m),
      .words_stored(big_words), .pkts_stored(big_pkts), .oversize_err(big_err),
      .err_clr(big_clr), .pkt_count(big_cnt)
   );

   axis_pkt_fifo #(.DATA_W(32), .DEPTH(8)) u_small (
      .ACLK(ACLK), .ARESETn(ARESETn), .s_axis(small_s), .m_axis(small_m),
      .words_stored(small_words), .pkts_stored(small_pkts), .oversize_err(small_err),
      .err_clr(small_clr), .pkt_count(small_cnt)
   );

   logic        obs_s_tready, obs_m_tvalid, obs_m_tlast, obs_err;
   logic [31:0] obs_m_tdata, obs_words, obs_pkts;
   logic [15:0] obs_cnt;

   always_comb begin
      if (sel) begin
         obs_s_tready = small_s.tready;
         obs_m_tvalid = small_m.tvalid;
         obs_m_tlast  = small_m.tlast;
         obs_m_tdata  = small_m.tdata;
         obs_words    = 32'(small_words);
         obs_pkts     = 32'(small_pkts);
         obs_err      = small_err;
         obs_cnt      = small_cnt;
      end else begin
         obs_s_tready = big_s.tready;
         obs_m_tvalid = big_m.tvalid;
         obs_m_tlast  = big_m.tlast;
         obs_m_tdata  = big_m.tdata;
         obs_words    = 32'(big_words);
         obs_pkts     = 32'(big_pkts);
         obs_err      = big_err;
         obs_cnt      = big_cnt;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Any beat presented with m_tready high is logged before the edge that transfers it.
   task automatic tick();
      if (obs_m_tvalid && m_tready) begin
         if (out_q.size() == 0) first_emit = cyc;
         last_emit = cyc;
         out_q.push_back({obs_m_tlast, obs_m_tdata});
      end
      @(posedge ACLK);
      #1;
      cyc++;
   endtask

   task automatic applyReset();
      ARESETn  = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      m_tready = 1'b0;
      err_clr  = 1'b0;
      tick();
      tick();
      checkOutput("rst s_tready", 64'(obs_s_tready), 64'd0);
      checkOutput("rst m_tvalid", 64'(obs_m_tvalid), 64'd0);
      checkOutput("rst m_tlast", 64'(obs_m_tlast), 64'd0);
      checkOutput("rst m_tdata", 64'(obs_m_tdata), 64'd0);
      checkOutput("rst words_stored", 64'(obs_words), 64'd0);
      checkOutput("rst pkts_stored", 64'(obs_pkts), 64'd0);
      checkOutput("rst oversize_err", 64'(obs_err), 64'd0);
      checkOutput("rst pkt_count", 64'(obs_cnt), 64'd0);
      ARESETn = 1'b1;
      tick();
      checkOutput("release s_tready", 64'(obs_s_tready), 64'd1);
      out_q.delete();
   endtask

   task automatic applyStimulus(input logic [31:0] data, input logic last);
      logic acc;
      int   n;
      n        = 0;
      s_tvalid = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      do begin
         acc = obs_s_tready;
         tick();
         n++;
      end while (!acc && n < 200);
      checkOutput("beat accepted", 64'(acc), 64'd1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input int target, input int bound);
      int n;
      n = 0;
      while (out_q.size() < target && n < bound) begin
         tick();
         n++;
      end
      checkOutput("drain count", 64'(out_q.size()), 64'(target));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          errs, lasts, stall_errs, n, valid_seen;
      logic        prev_v;
      logic [31:0] prev_d;
      logic [32:0] exp;
      logic [15:0] exp_cnt;

      sel = 1'b0;

      // Single 4-beat packet: nothing until TLAST, then valid two edges later and four gap-free beats.
      applyReset();
      m_tready = 1'b1;
      applyStimulus(32'h11, 1'b0);
      checkOutput("t1 no early valid a", 64'(obs_m_tvalid), 64'd0);
      applyStimulus(32'h22, 1'b0);
      applyStimulus(32'h33, 1'b0);
      checkOutput("t1 no early valid b", 64'(obs_m_tvalid), 64'd0);
      checkOutput("t1 pkts before last", 64'(obs_pkts), 64'd0);
      applyStimulus(32'h44, 1'b1);
      checkOutput("t1 valid +0", 64'(obs_m_tvalid), 64'd0);
      checkOutput("t1 pkts after commit", 64'(obs_pkts), 64'd1);
      checkOutput("t1 words after commit", 64'(obs_words), 64'd4);
      tick();
      checkOutput("t1 valid +1", 64'(obs_m_tvalid), 64'd0);
      tick();
      checkOutput("t1 valid +2", 64'(obs_m_tvalid), 64'd1);
      repeat (4) tick();
      checkOutput("t1 beat count", 64'(out_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         exp = {1'(i == 3), 32'((i + 1) * 32'h11)};
         checkOutput($sformatf("t1 beat %0d", i), 64'(out_q[i]), 64'(exp));
      end
      checkOutput("t1 pkts after emit", 64'(obs_pkts), 64'd0);
      checkOutput("t1 words after emit", 64'(obs_words), 64'd0);

      // Back-to-back packets of 256 and 1 words stream out as 257 consecutive beats.
      applyReset();
      m_tready = 1'b1;
      for (int i = 0; i < 256; i++) applyStimulus(32'(i + 32'h100), i == 255);
      applyStimulus(32'h1000, 1'b1);
      drain(257, 400);
      errs  = 0;
      lasts = 0;
      for (int i = 0; i < 257; i++) begin
         exp = (i < 256) ? {1'(i == 255), 32'(i + 32'h100)} : {1'b1, 32'h1000};
         if (out_q[i] !== exp) errs++;
         if (out_q[i][32]) lasts++;
      end
      checkOutput("t2 data errors", 64'(errs), 64'd0);
      checkOutput("t2 tlast pulses", 64'(lasts), 64'd2);
      checkOutput("t2 gap-free span", 64'(last_emit - first_emit), 64'd256);
`ifdef AXIS_PKT_FIFO_PKT_COUNT_EN
      exp_cnt = 16'd2;
`else
      exp_cnt = 16'd0;
`endif
      checkOutput("t2 pkt_count", 64'(obs_cnt), 64'(exp_cnt));
      checkOutput("t2 pkts drained", 64'(obs_pkts), 64'd0);

      // Toggling backpressure: order preserved and output held while stalled.
      applyReset();
      for (int i = 0; i < 16; i++) applyStimulus(32'(32'hA0 + i), i == 15);
      stall_errs = 0;
      n          = 0;
      while (out_q.size() < 16 && n < 100) begin
         m_tready = 1'(n % 2);
         prev_v   = obs_m_tvalid;
         prev_d   = obs_m_tdata;
         tick();
         if (prev_v && !m_tready && (!obs_m_tvalid || obs_m_tdata !== prev_d)) stall_errs++;
         n++;
      end
      m_tready = 1'b0;
      checkOutput("t3 beat count", 64'(out_q.size()), 64'd16);
      errs = 0;
      for (int i = 0; i < 16; i++) begin
         exp = {1'(i == 15), 32'(32'hA0 + i)};
         if (out_q[i] !== exp) errs++;
      end
      checkOutput("t3 data errors", 64'(errs), 64'd0);
      checkOutput("t3 stall stability errors", 64'(stall_errs), 64'd0);

      // DEPTH=8: an 8-word packet fills the FIFO; ready returns after the first emission.
      sel = 1'b1;
      applyReset();
      for (int i = 0; i < 7; i++) applyStimulus(32'(32'h80 + i), 1'b0);
      checkOutput("t4 ready with one slot", 64'(obs_s_tready), 64'd1);
      applyStimulus(32'h87, 1'b1);
      checkOutput("t4 s_tready full", 64'(obs_s_tready), 64'd0);
      checkOutput("t4 words full", 64'(obs_words), 64'd8);
      tick();
      tick();
      checkOutput("t4 full holds", 64'(obs_s_tready), 64'd0);
      checkOutput("t4 output loaded", 64'(obs_m_tvalid), 64'd1);
      checkOutput("t4 words still 8", 64'(obs_words), 64'd8);
      m_tready = 1'b1;
      tick();
      checkOutput("t4 words after emit", 64'(obs_words), 64'd7);
      checkOutput("t4 s_tready back", 64'(obs_s_tready), 64'd1);
      drain(8, 50);
      errs = 0;
      for (int i = 0; i < 8; i++) begin
         exp = {1'(i == 7), 32'(32'h80 + i)};
         if (out_q[i] !== exp) errs++;
      end
      checkOutput("t4 data errors", 64'(errs), 64'd0);
      checkOutput("t4 no oversize", 64'(obs_err), 64'd0);

      // DEPTH=8: a 10-word packet is split into a forced 8-word segment and a 2-word tail.
      applyReset();
      for (int i = 0; i < 8; i++) applyStimulus(32'(32'hC0 + i), 1'b0);
      checkOutput("t5 oversize_err set", 64'(obs_err), 64'd1);
      checkOutput("t5 forced commit", 64'(obs_pkts), 64'd1);
      checkOutput("t5 s_tready full", 64'(obs_s_tready), 64'd0);
      m_tready = 1'b1;
      applyStimulus(32'hC8, 1'b0);
      applyStimulus(32'hC9, 1'b1);
      drain(10, 60);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         exp = {1'(i == 7 || i == 9), 32'(32'hC0 + i)};
         if (out_q[i] !== exp) errs++;
      end
      checkOutput("t5 data errors", 64'(errs), 64'd0);
      checkOutput("t5 err sticky", 64'(obs_err), 64'd1);
      checkOutput("t5 pkts drained", 64'(obs_pkts), 64'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("t5 err cleared", 64'(obs_err), 64'd0);

      // Reset in the middle of a packet discards it; the next packet is emitted cleanly.
      sel = 1'b0;
      applyReset();
      m_tready = 1'b1;
      applyStimulus(32'hD0, 1'b0);
      applyStimulus(32'hD1, 1'b0);
      applyStimulus(32'hD2, 1'b0);
      applyReset();
      m_tready   = 1'b1;
      valid_seen = 0;
      repeat (5) begin
         tick();
         if (obs_m_tvalid) valid_seen++;
      end
      checkOutput("t6 no stale output", 64'(valid_seen), 64'd0);
      checkOutput("t6 words empty", 64'(obs_words), 64'd0);
      applyStimulus(32'hE0, 1'b0);
      applyStimulus(32'hE1, 1'b1);
      drain(2, 20);
      repeat (3) tick();
      checkOutput("t6 beat count", 64'(out_q.size()), 64'd2);
      checkOutput("t6 beat 0", 64'(out_q[0]), 64'({1'b0, 32'hE0}));
      checkOutput("t6 beat 1", 64'(out_q[1]), 64'({1'b1, 32'hE1}));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
